// File: rtl/fl_arb_pkg.sv
// Shared types and width helpers for the FrameLink FIFO arbiter.
package fl_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } fl_state_e;

    // REM carries the byte index of the last valid byte; keep at least one bit.
    function automatic int rem_width(input int data_width);
        int w;
        w = $clog2(data_width / 8);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/fl_fifo_arbiter_if.sv
// FrameLink requester/FIFO bundle; slave modport faces the arbiter.
interface fl_fifo_arbiter_if
    import fl_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int PORTS        = 4,
    parameter int STATUS_WIDTH = 4
) ();
    localparam int REM_WIDTH = rem_width(DATA_WIDTH);

    logic [PORTS*DATA_WIDTH-1:0] RX_DATA;
    logic [PORTS*REM_WIDTH-1:0]  RX_REM;
    logic [PORTS-1:0]            RX_SOF_N;
    logic [PORTS-1:0]            RX_EOF_N;
    logic [PORTS-1:0]            RX_SOP_N;
    logic [PORTS-1:0]            RX_EOP_N;
    logic [PORTS-1:0]            RX_SRC_RDY_N;
    logic [PORTS-1:0]            RX_DST_RDY_N;

    logic [DATA_WIDTH-1:0]       TX_DATA;
    logic [REM_WIDTH-1:0]        TX_REM;
    logic                        TX_SOF_N;
    logic                        TX_EOF_N;
    logic                        TX_SOP_N;
    logic                        TX_EOP_N;
    logic                        TX_SRC_RDY_N;
    logic                        TX_DST_RDY_N;

    logic [STATUS_WIDTH-1:0]     FIFO_STATUS;
    logic                        FIFO_FULL;
    logic [PORTS-1:0]            GRANT;
    logic [31:0]                 FRAME_CNT;

    modport slave (
        input  RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N,
        output RX_DST_RDY_N,
        output TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N,
        input  TX_DST_RDY_N,
        input  FIFO_STATUS, FIFO_FULL,
        output GRANT, FRAME_CNT
    );

    modport master (
        output RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N,
        input  RX_DST_RDY_N,
        input  TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N,
        output TX_DST_RDY_N,
        output FIFO_STATUS, FIFO_FULL,
        input  GRANT, FRAME_CNT
    );
endinterface

// File: rtl/fl_rr_select.sv
// Combinational round-robin picker: first request at or after last_grant+1.
module fl_rr_select
    import fl_arb_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]            i_req,
    input  logic [idx_width(PORTS)-1:0] i_last,
    output logic [PORTS-1:0]            o_gnt,
    output logic                        o_valid
);
    localparam int IDXW = idx_width(PORTS);

    logic [IDXW-1:0] w_idx;

    // Walk from the farthest offset inward so the nearest requester wins.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int off = PORTS; off >= 1; off--) begin
            w_idx = IDXW'((int'(i_last) + off) % PORTS);
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fl_fifo_arbiter.sv
// Frame-granular round-robin arbiter merging FrameLink requesters into one FIFO.
module fl_fifo_arbiter
    import fl_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int PORTS        = 4,
    parameter int STATUS_WIDTH = 4,
    parameter int MIN_FREE     = 2
) (
    input logic              CLK,
    input logic              RESET_N,
    fl_fifo_arbiter_if.slave bus
);
    localparam int IDXW = idx_width(PORTS);
    localparam int RW   = rem_width(DATA_WIDTH);

    localparam logic [0:0] S_IDLE   = IDLE;
    localparam logic [0:0] S_LOCKED = LOCKED;

    logic [0:0]       r_state;
    logic [PORTS-1:0] r_grant;
    logic [IDXW-1:0]  r_last;
    logic [31:0]      r_frame_cnt;

    logic [PORTS-1:0]      w_cand;
    logic [PORTS-1:0]      w_pick;
    logic                  w_pick_valid;
    logic                  w_fifo_ok;
    logic                  w_locked;
    logic [IDXW-1:0]       w_gidx;
    logic [IDXW-1:0]       w_sel;
    logic                  w_xfer;
    logic                  w_eof_xfer;
    logic [DATA_WIDTH-1:0] w_rx_data [PORTS];
    logic [RW-1:0]         w_rx_rem  [PORTS];

    assign w_cand    = ~bus.RX_SRC_RDY_N & ~bus.RX_SOF_N;
    assign w_fifo_ok = (int'(bus.FIFO_STATUS) >= MIN_FREE) && !bus.FIFO_FULL;
    assign w_locked  = (r_state == S_LOCKED);

    fl_rr_select #(.PORTS(PORTS)) u_rr (
        .i_req   (w_cand),
        .i_last  (r_last),
        .o_gnt   (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (r_grant[i]) w_gidx = IDXW'(i);
        end
    end

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            assign w_rx_data[gi]        = bus.RX_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_rx_rem[gi]         = bus.RX_REM[gi*RW +: RW];
            assign bus.RX_DST_RDY_N[gi] = (w_locked && r_grant[gi]) ? bus.TX_DST_RDY_N : 1'b1;
        end
    endgenerate

    // Idle parks the mux on port 0; only SRC_RDY needs to be forced inactive.
    assign w_sel            = w_locked ? w_gidx : '0;
    assign bus.TX_DATA      = w_rx_data[w_sel];
    assign bus.TX_REM       = w_rx_rem[w_sel];
    assign bus.TX_SOF_N     = bus.RX_SOF_N[w_sel];
    assign bus.TX_EOF_N     = bus.RX_EOF_N[w_sel];
    assign bus.TX_SOP_N     = bus.RX_SOP_N[w_sel];
    assign bus.TX_EOP_N     = bus.RX_EOP_N[w_sel];
    assign bus.TX_SRC_RDY_N = w_locked ? bus.RX_SRC_RDY_N[w_sel] : 1'b1;

    assign w_xfer     = !bus.TX_SRC_RDY_N && !bus.TX_DST_RDY_N;
    assign w_eof_xfer = w_xfer && !bus.TX_EOF_N;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last      <= IDXW'(PORTS - 1);
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid && w_fifo_ok) begin
                        r_state <= S_LOCKED;
                        r_grant <= w_pick;
                    end
                end
                default: begin
                    if (w_eof_xfer) begin
                        r_state     <= S_IDLE;
                        r_grant     <= '0;
                        r_last      <= w_gidx;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    assign bus.GRANT     = r_grant;
    assign bus.FRAME_CNT = r_frame_cnt;
endmodule
